// File: rtl/sync_fifo_spram_fwft_pkg.sv
// Shared constants and sizing helpers for the banked FWFT FIFO.
// Storage is rounded up to an even depth so it splits into two equal banks.
package sync_fifo_spram_fwft_pkg;

  localparam logic [1:0] SEL_BYP  = 2'd0;
  localparam logic [1:0] SEL_EVEN = 2'd1;
  localparam logic [1:0] SEL_ODD  = 2'd2;

  function automatic int adepth_f(input int depth);
    return depth + (depth % 2);
  endfunction

  function automatic int aw_f(input int depth);
    return $clog2(adepth_f(depth));
  endfunction

  function automatic int raw_f(input int depth);
    return (aw_f(depth) > 1) ? aw_f(depth) - 1 : 1;
  endfunction

  function automatic int cw_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_spram_fwft_if.sv
// Push/pop and status bundle of the banked FWFT FIFO.
// master drives the FIFO, slave is the FIFO itself.
interface sync_fifo_spram_fwft_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) ();
  import sync_fifo_spram_fwft_pkg::*;

  logic             clear;
  logic             wr;
  logic [WIDTH-1:0] din;
  logic             rd;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    used_cnt;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, wr, din, rd,
    input  dout, used_cnt, full, empty,
    input  almost_full, almost_empty,
    input  overflow, underflow
  );

  modport slave (
    input  clear, wr, din, rd,
    output dout, used_cnt, full, empty,
    output almost_full, almost_empty,
    output overflow, underflow
  );

endinterface

// File: rtl/sp_ram_model.sv
// Single-port RAM, one access per cycle, registered read data.
// rdata only changes on a read, so it keeps the last word read.
module sp_ram_model #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Occupancy counter with registered full/empty/threshold flags
// and sticky overflow/underflow; also qualifies raw wr/rd requests.
module sync_fifo_flags
  import sync_fifo_spram_fwft_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr,
  input  logic          rd,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [CW-1:0] nxt;

  // a pop frees a slot, so a full FIFO still takes a write alongside it
  assign rd_ok = rd & ~empty & ~clear;
  assign wr_ok = wr & (~full | rd) & ~clear;
  assign nxt   = cnt + CW'(wr_ok) - CW'(rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clear) begin
      cnt          <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      cnt          <= nxt;
      full         <= (nxt == DEPTH_C);
      empty        <= (nxt == '0);
      almost_full  <= (nxt >= AF_C);
      almost_empty <= (nxt <= AE_C);
      overflow     <= overflow | (wr & full & ~rd);
      underflow    <= underflow | (rd & empty);
    end
  end

endmodule

// File: rtl/sync_fifo_spram_fwft.sv
// First-word-fall-through FIFO over two single-port RAM banks
// (even/odd interleave) with a one-entry holding register for bank clashes.
module sync_fifo_spram_fwft
  import sync_fifo_spram_fwft_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sync_fifo_spram_fwft_if.slave bus
);

  localparam int ADEPTH     = adepth_f(DEPTH);
  localparam int AW         = aw_f(DEPTH);
  localparam int RAW        = raw_f(DEPTH);
  localparam int BANK_DEPTH = ADEPTH / 2;
  localparam int CW         = cw_f(DEPTH);

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(ADEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RAW-1:0] row(input logic [AW-1:0] p);
    return RAW'(p >> 1);
  endfunction

  logic             wr_ok;
  logic             rd_ok;
  logic             empty_q;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [AW-1:0]    pref_addr;
  logic [AW-1:0]    hold_addr;
  logic [WIDTH-1:0] hold_data;
  logic             hold_vld;
  logic [WIDTH-1:0] byp;
  logic [1:0]       sel;
  logic             pref;
  logic             drain;
  logic             to_hold;
  logic             wr_dir;
  logic [1:0]       d_hit;
  logic [1:0]       p_hit;
  logic [1:0]       w_hit;
  logic [1:0]       en;
  logic [1:0]       we;
  logic [RAW-1:0]   addr  [2];
  logic [WIDTH-1:0] wdata [2];
  logic [WIDTH-1:0] rdata [2];

  sync_fifo_flags #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL),
    .CW       (CW)
  ) u_flags (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (bus.clear),
    .wr           (bus.wr),
    .rd           (bus.rd),
    .wr_ok        (wr_ok),
    .rd_ok        (rd_ok),
    .cnt          (cnt),
    .full         (bus.full),
    .empty        (empty_q),
    .almost_full  (bus.almost_full),
    .almost_empty (bus.almost_empty),
    .overflow     (bus.overflow),
    .underflow    (bus.underflow)
  );

  assign bus.empty    = empty_q;
  assign bus.used_cnt = cnt;

  // raddr is the head; a pop prefetches the word behind it
  assign pref_addr = inc(raddr);
  assign pref      = rd_ok & (cnt != CW'(1));
  assign drain     = hold_vld & ~bus.clear;

  assign to_hold = wr_ok & (
    (pref & (waddr[0] == pref_addr[0])) |
    (drain & (waddr[0] == hold_addr[0])));
  assign wr_dir  = wr_ok & ~to_hold;

  assign d_hit = {drain & hold_addr[0], drain & ~hold_addr[0]};
  assign p_hit = {pref & pref_addr[0], pref & ~pref_addr[0]};
  assign w_hit = {wr_dir & waddr[0], wr_dir & ~waddr[0]};

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      en[b]    = d_hit[b] | p_hit[b] | w_hit[b];
      we[b]    = d_hit[b] | w_hit[b];
      addr[b]  = d_hit[b] ? row(hold_addr) :
                 w_hit[b] ? row(waddr) : row(pref_addr);
      wdata[b] = d_hit[b] ? hold_data : bus.din;
    end
  end

  sp_ram_model #(.DW(WIDTH), .DEPTH(BANK_DEPTH), .AW(RAW)) even_ram (
    .clk   (clk),
    .en    (en[0]),
    .we    (we[0]),
    .addr  (addr[0]),
    .wdata (wdata[0]),
    .rdata (rdata[0])
  );

  sp_ram_model #(.DW(WIDTH), .DEPTH(BANK_DEPTH), .AW(RAW)) odd_ram (
    .clk   (clk),
    .en    (en[1]),
    .we    (we[1]),
    .addr  (addr[1]),
    .wdata (wdata[1]),
    .rdata (rdata[1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr     <= '0;
      raddr     <= '0;
      hold_vld  <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      byp       <= '0;
      sel       <= SEL_BYP;
    end else if (bus.clear) begin
      waddr     <= '0;
      raddr     <= '0;
      hold_vld  <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      byp       <= '0;
      sel       <= SEL_BYP;
    end else begin
      if (wr_ok) waddr <= inc(waddr);
      if (rd_ok) raddr <= pref_addr;
      hold_vld <= to_hold;
      if (to_hold) begin
        hold_addr <= waddr;
        hold_data <= bus.din;
      end
      // incoming word becomes the head straight away when nothing is ahead of it
      if (wr_ok & (empty_q | (rd_ok & (cnt == CW'(1))))) begin
        byp <= bus.din;
        sel <= SEL_BYP;
      end else if (pref) begin
        sel <= pref_addr[0] ? SEL_ODD : SEL_EVEN;
      end
    end
  end

  assign bus.dout = (sel == SEL_EVEN) ? rdata[0] :
                    (sel == SEL_ODD)  ? rdata[1] : byp;

endmodule

// File: tb/tb_sync_fifo_spram_fwft.sv
// Bench for the banked FWFT FIFO: DEPTH=8 and DEPTH=5 instances share stimulus,
// each tracked by a queue model; directed table and sequences on top.
module tb_sync_fifo_spram_fwft;
  import sync_fifo_spram_fwft_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_spram_fwft_if #(.WIDTH(W), .CW(CW)) bus8 ();
  sync_fifo_spram_fwft_if #(.WIDTH(W), .CW(CW)) bus5 ();

  sync_fifo_spram_fwft #(
    .WIDTH(W), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  sync_fifo_spram_fwft #(
    .WIDTH(W), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5)
  );

  typedef struct {
    logic       c;
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [9:0] st;
    logic [7:0] dout;
    bit         cd;
  } vec_t;

  vec_t tbl [23];

  logic [7:0] mq [2][$];
  bit m_ovf [2];
  bit m_udf [2];
  bit m_zero [2];
  int dep [2] = '{8, 5};
  int afl [2] = '{6, 4};
  int ael [2] = '{1, 1};

  int checks = 0;
  int errors = 0;

  function automatic logic [9:0] st(input int n, input bit f, e, af, ae, o, u);
    return {4'(n), f, e, af, ae, o, u};
  endfunction

  function automatic vec_t mk(input logic c, w, r, input logic [7:0] d,
                              input logic [9:0] s, input logic [7:0] q, input bit cd);
    vec_t v;
    v.c = c; v.w = w; v.r = r; v.d = d;
    v.st = s; v.dout = q; v.cd = cd;
    return v;
  endfunction

  function automatic logic [17:0] obs(input int i);
    if (i == 0)
      return {bus8.used_cnt, bus8.full, bus8.empty, bus8.almost_full,
              bus8.almost_empty, bus8.overflow, bus8.underflow, bus8.dout};
    return {bus5.used_cnt, bus5.full, bus5.empty, bus5.almost_full,
            bus5.almost_empty, bus5.overflow, bus5.underflow, bus5.dout};
  endfunction

  task automatic chk(input string name, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic mstep(input int i, input logic c, w, r, input logic [7:0] d);
    int n;
    bit f;
    bit e;
    n = mq[i].size();
    f = (n == dep[i]);
    e = (n == 0);
    if (c) begin
      mq[i].delete();
      m_ovf[i] = 0;
      m_udf[i] = 0;
      m_zero[i] = 1;
    end else begin
      if (w && f && !r) m_ovf[i] = 1;
      if (r && e) m_udf[i] = 1;
      if (r && !e) void'(mq[i].pop_front());
      if (w && (!f || r)) begin
        mq[i].push_back(d);
        m_zero[i] = 0;
      end
    end
  endtask

  task automatic mcheck(input int i);
    int n;
    logic [17:0] g;
    logic [9:0] es;
    n = mq[i].size();
    g = obs(i);
    es = {4'(n), n == dep[i], n == 0, n >= afl[i], n <= ael[i], m_ovf[i], m_udf[i]};
    chk($sformatf("dut%0d_status", i), {8'h00, g[17:8]}, {8'h00, es});
    if (n > 0)
      chk($sformatf("dut%0d_head", i), {10'h0, g[7:0]}, {10'h0, mq[i][0]});
    else if (m_zero[i])
      chk($sformatf("dut%0d_dout_zero", i), {10'h0, g[7:0]}, 18'h0);
  endtask

  task automatic cyc(input logic c, w, r, input logic [7:0] d);
    bus8.clear = c; bus8.wr = w; bus8.rd = r; bus8.din = d;
    bus5.clear = c; bus5.wr = w; bus5.rd = r; bus5.din = d;
    for (int i = 0; i < 2; i++) mstep(i, c, w, r, d);
    @(negedge clk);
    for (int i = 0; i < 2; i++) mcheck(i);
  endtask

  initial begin
    logic [7:0] dv;
    int pw;
    logic rc, rw, rr;

    tbl[0]  = mk(0, 1, 0, 8'h01, st(1, 0, 0, 0, 1, 0, 0), 8'h01, 1);
    tbl[1]  = mk(0, 1, 0, 8'h02, st(2, 0, 0, 0, 0, 0, 0), 8'h01, 1);
    tbl[2]  = mk(0, 1, 0, 8'h03, st(3, 0, 0, 0, 0, 0, 0), 8'h01, 1);
    tbl[3]  = mk(0, 1, 0, 8'h04, st(4, 0, 0, 0, 0, 0, 0), 8'h01, 1);
    tbl[4]  = mk(0, 1, 0, 8'h05, st(5, 0, 0, 0, 0, 0, 0), 8'h01, 1);
    tbl[5]  = mk(0, 1, 0, 8'h06, st(6, 0, 0, 1, 0, 0, 0), 8'h01, 1);
    tbl[6]  = mk(0, 1, 0, 8'h07, st(7, 0, 0, 1, 0, 0, 0), 8'h01, 1);
    tbl[7]  = mk(0, 1, 0, 8'h08, st(8, 1, 0, 1, 0, 0, 0), 8'h01, 1);
    tbl[8]  = mk(0, 1, 0, 8'hFF, st(8, 1, 0, 1, 0, 1, 0), 8'h01, 1);
    tbl[9]  = mk(0, 0, 1, 8'h00, st(7, 0, 0, 1, 0, 1, 0), 8'h02, 1);
    tbl[10] = mk(0, 0, 1, 8'h00, st(6, 0, 0, 1, 0, 1, 0), 8'h03, 1);
    tbl[11] = mk(0, 0, 1, 8'h00, st(5, 0, 0, 0, 0, 1, 0), 8'h04, 1);
    tbl[12] = mk(0, 0, 1, 8'h00, st(4, 0, 0, 0, 0, 1, 0), 8'h05, 1);
    tbl[13] = mk(0, 0, 1, 8'h00, st(3, 0, 0, 0, 0, 1, 0), 8'h06, 1);
    tbl[14] = mk(0, 0, 1, 8'h00, st(2, 0, 0, 0, 0, 1, 0), 8'h07, 1);
    tbl[15] = mk(0, 0, 1, 8'h00, st(1, 0, 0, 0, 1, 1, 0), 8'h08, 1);
    tbl[16] = mk(0, 0, 1, 8'h00, st(0, 0, 1, 0, 1, 1, 0), 8'h00, 0);
    tbl[17] = mk(0, 0, 1, 8'h00, st(0, 0, 1, 0, 1, 1, 1), 8'h00, 0);
    tbl[18] = mk(1, 1, 0, 8'hAA, st(0, 0, 1, 0, 1, 0, 0), 8'h00, 1);
    tbl[19] = mk(0, 1, 0, 8'hA5, st(1, 0, 0, 0, 1, 0, 0), 8'hA5, 1);
    tbl[20] = mk(0, 1, 1, 8'hB6, st(1, 0, 0, 0, 1, 0, 0), 8'hB6, 1);
    tbl[21] = mk(0, 1, 1, 8'hC7, st(1, 0, 0, 0, 1, 0, 0), 8'hC7, 1);
    tbl[22] = mk(0, 0, 1, 8'h00, st(0, 0, 1, 0, 1, 0, 0), 8'h00, 0);

    bus8.clear = 0; bus8.wr = 0; bus8.rd = 0; bus8.din = '0;
    bus5.clear = 0; bus5.wr = 0; bus5.rd = 0; bus5.din = '0;
    for (int i = 0; i < 2; i++) mstep(i, 1, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    chk("reset_status", {8'h00, obs(0)[17:8]}, {8'h00, st(0, 0, 1, 0, 1, 0, 0)});
    chk("reset_dout", {10'h0, bus8.dout}, 18'h0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) mcheck(i);

    for (int k = 0; k < 23; k++) begin
      cyc(tbl[k].c, tbl[k].w, tbl[k].r, tbl[k].d);
      chk($sformatf("tbl%0d_status", k), {8'h00, obs(0)[17:8]}, {8'h00, tbl[k].st});
      if (tbl[k].cd)
        chk($sformatf("tbl%0d_dout", k), {10'h0, bus8.dout}, {10'h0, tbl[k].dout});
    end

    for (int n = 3; n <= 4; n++) begin
      cyc(1, 0, 0, 8'h00);
      for (int j = 0; j < n; j++) cyc(0, 1, 0, 8'(8'h10 + j));
      for (int k = 0; k < 20; k++) begin
        cyc(0, 1, 1, 8'(8'h10 + n + k));
        chk($sformatf("rdwr%0d_dout_%0d", n, k), {10'h0, bus8.dout}, 18'(8'h10 + k + 1));
        chk($sformatf("rdwr%0d_cnt_%0d", n, k), {14'h0, bus8.used_cnt}, 18'(n));
      end
    end

    cyc(1, 0, 0, 8'h00);
    for (int j = 0; j < 8; j++) cyc(0, 1, 0, 8'(8'h20 + j));
    cyc(0, 1, 1, 8'h30);
    chk("full_rdwr", {4'h0, bus8.used_cnt, bus8.full, bus8.overflow, bus8.dout},
        {4'h0, 4'd8, 1'b1, 1'b0, 8'h21});

    cyc(1, 0, 0, 8'h00);
    dv = 8'h40;
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 3 + b; j++) begin
        cyc(0, 1, 0, dv);
        dv++;
      end
      if (b == 1) chk("d5_full", {13'h0, bus5.full, bus5.used_cnt}, {13'h0, 1'b1, 4'd5});
      for (int j = 0; j < 2 + b; j++) cyc(0, 0, 1, 8'h00);
    end
    for (int j = 0; j < 8; j++) cyc(0, 0, 1, 8'h00);

    for (int k = 0; k < 600; k++) begin
      pw = ((k / 100) % 3 == 0) ? 80 : ((k / 100) % 3 == 1) ? 25 : 55;
      rc = ($urandom_range(0, 149) == 0);
      rw = ($urandom_range(0, 99) < pw);
      rr = ($urandom_range(0, 99) < (110 - pw));
      cyc(rc, rw, rr, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
